// File: rtl/reg_bank_store_if.sv
// Bus-side signal bundle of the register bank: select strobes, write data,
// read data and status.
interface reg_bank_store_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  logic [NREGS-1:0] r_in;
  logic [NREGS-1:0] r_out;
  logic             ba_out;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic             bus_out_en;
  logic             err_clr;
  logic             strobe_err;
  logic [15:0]      wr_count;

  modport master (
    output r_in, r_out, ba_out, bus_in, err_clr,
    input  bus_out, bus_out_en, strobe_err, wr_count
  );

  modport slave (
    input  r_in, r_out, ba_out, bus_in, err_clr,
    output bus_out, bus_out_en, strobe_err, wr_count
  );
endinterface

// File: rtl/reg_bank_store.sv
// Sixteen-entry register storage driven by one-hot read/write strobes, with a
// sticky multi-hot strobe error. Optional macro: REG_BANK_R0_ZERO_EN.
module reg_bank_store #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  reg_bank_store_if.slave  bus
);

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  function automatic logic is_one_hot(input logic [NREGS-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  function automatic logic is_multi_hot(input logic [NREGS-1:0] v);
    return (v & (v - ONE)) != '0;
  endfunction

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_data;
  logic             wr_ok;
  logic             rd_ok;
  logic             violation;
  logic             strobe_err_q;
  logic [15:0]      wr_count_q;

  assign wr_ok     = is_one_hot(bus.r_in);
  assign rd_ok     = is_one_hot(bus.r_out);
  assign violation = is_multi_hot(bus.r_in) || is_multi_hot(bus.r_out);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NREGS; k++)
        if (bus.r_in[k]) regs[k] <= bus.bus_in;
    end
  end

  // A new violation outranks a simultaneous clear request.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      strobe_err_q <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      if (violation)        strobe_err_q <= 1'b1;
      else if (bus.err_clr) strobe_err_q <= 1'b0;
      if (wr_ok) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // AND-OR mux; only meaningful when exactly one read strobe is set.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NREGS; k++)
      if (bus.r_out[k]) rd_data = rd_data | regs[k];
  end

  always_comb begin
    bus.bus_out    = '0;
    bus.bus_out_en = 1'b0;
    if (rd_ok) begin
      bus.bus_out    = rd_data;
      bus.bus_out_en = 1'b1;
    end
`ifdef REG_BANK_R0_ZERO_EN
    // Base-address read of R0 yields a literal zero while still driving.
    if (rd_ok && bus.ba_out && bus.r_out[0]) bus.bus_out = '0;
`else
    begin : ba_unused_blk
    end
`endif
  end

`ifndef REG_BANK_R0_ZERO_EN
  logic unused_ba;
  assign unused_ba = bus.ba_out;
`endif

  assign bus.strobe_err = strobe_err_q;
  assign bus.wr_count   = wr_count_q;

endmodule
